conv1_dense_seq_ctrl: RTL and testbench

Sequencer for the conv1 layer-1 dense datapath. Fetches 400-bit feature words from the global input-feature BRAM and walks the 16-bit element select across each word (bypass path), or issues whole words to the matrix mult/adder-tree path (mx path). Counts elements delivered to the 1x64 parallel multiplier, drains the pipeline after each accumulation group, then clears the 64-channel self-add register heap. Sits beside the dense top and drives its col-select, valid, usr_rst and done signals.

---
 rtl/conv1_dense_seq_ctrl_if.sv | 40 ++++
 rtl/conv1_dense_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_conv1_dense_seq_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_dense_seq_ctrl_if.sv
// Handshake bundle between the conv1 dense sequencer (slave) and its host/datapath side (master).
// With CONV1_SEQ_STALL_CNT_EN defined, the bundle also carries stall_cnt.
interface conv1_dense_seq_ctrl_if #(
  parameter int COL_W = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic             cfg_mx_en;
  logic             halt;
  logic             fea_v;
  logic             fea_req;
  logic [COL_W-1:0] col_sel;
  logic             elem_v;
  logic             mx_issue;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] grp_cnt;
`ifdef CONV1_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output start, cfg_mx_en, halt, fea_v,
    input  fea_req, col_sel, elem_v, mx_issue, acc_clr, busy, done, grp_cnt, stall_cnt
  );
  modport slave (
    input  start, cfg_mx_en, halt, fea_v,
    output fea_req, col_sel, elem_v, mx_issue, acc_clr, busy, done, grp_cnt, stall_cnt
  );
`else
  modport master (
    output start, cfg_mx_en, halt, fea_v,
    input  fea_req, col_sel, elem_v, mx_issue, acc_clr, busy, done, grp_cnt
  );
  modport slave (
    input  start, cfg_mx_en, halt, fea_v,
    output fea_req, col_sel, elem_v, mx_issue, acc_clr, busy, done, grp_cnt
  );
`endif
endinterface

// File: rtl/conv1_dense_seq_ctrl.sv
// Sequencer for the conv1 layer-1 dense datapath: fetch, issue (bypass or mx), drain, clear.
// Optional CONV1_SEQ_STALL_CNT_EN adds a saturating count of halted busy cycles (stall_cnt).
module conv1_dense_seq_ctrl #(
  parameter int NUM_COL   = 25,
  parameter int COL_W     = 5,
  parameter int ACC_LEN   = 75,
  parameter int NUM_GRP   = 64,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 4,
  parameter int MX_LAT    = 6
) (
  input logic                   clk,
  input logic                   rst,
  conv1_dense_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_WORD, S_ISSUE, S_DRAIN, S_CLEAR, S_DONE
  } state_e;

  localparam int                 DRN_W    = $clog2(DRAIN_CYC + MX_LAT + 1);
  // DRAIN holds one cycle fewer than the drain length: the CLEAR cycle itself completes it.
  localparam logic [DRN_W-1:0]   DRN_BYP  = DRN_W'(DRAIN_CYC - 1);
  localparam logic [DRN_W-1:0]   DRN_MX   = DRN_W'(DRAIN_CYC + MX_LAT - 1);
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(NUM_COL - 1);
  localparam logic [CNT_W-1:0]   ACC_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0]   GRP_LAST = CNT_W'(NUM_GRP - 1);

  state_e           state_q, state_d;
  logic             mx_q, mx_d;
  logic             pend_q, pend_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] elem_q, elem_d;
  logic [CNT_W-1:0] grp_q, grp_d;
  logic [DRN_W-1:0] drn_q, drn_d;
`ifdef CONV1_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
    state_d = state_q;
    mx_d    = mx_q;
    pend_d  = pend_q;
    col_d   = col_q;
    elem_d  = elem_q;
    grp_d   = grp_q;
    drn_d   = drn_q;

    // A word that cannot be consumed right now is remembered for the next WAIT_WORD.
    if (bus.fea_v && (bus.halt || state_q != S_WAIT_WORD)) pend_d = 1'b1;

    if (!bus.halt) begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          mx_d    = bus.cfg_mx_en;
          pend_d  = 1'b0;
          col_d   = '0;
          elem_d  = '0;
          grp_d   = '0;
          state_d = S_FETCH;
        end
        S_FETCH: state_d = S_WAIT_WORD;
        S_WAIT_WORD: if (bus.fea_v || pend_q) begin
          pend_d  = 1'b0;
          col_d   = '0;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          elem_d = elem_q + 1'b1;
          if (!mx_q) col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          if (elem_q == ACC_LAST) begin
            drn_d   = mx_q ? DRN_MX : DRN_BYP;
            state_d = S_DRAIN;
          end else if (mx_q || col_q == COL_LAST) begin
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (drn_q <= DRN_W'(1)) state_d = S_CLEAR;
          else                    drn_d   = drn_q - 1'b1;
        end
        S_CLEAR: begin
          elem_d = '0;
          grp_d  = grp_q + 1'b1;
          // A partly consumed bypass word feeds the next group without a refetch.
          if (grp_q == GRP_LAST)        state_d = S_DONE;
          else if (!mx_q && col_q != '0) state_d = S_ISSUE;
          else                           state_d = S_FETCH;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef CONV1_SEQ_STALL_CNT_EN
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.start && !bus.halt)           stall_d = '0;
    else if (state_q != S_IDLE && bus.halt && stall_q != '1)   stall_d = stall_q + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state_q <= S_IDLE;
      mx_q    <= 1'b0;
      pend_q  <= 1'b0;
      col_q   <= '0;
      elem_q  <= '0;
      grp_q   <= '0;
      drn_q   <= '0;
`ifdef CONV1_SEQ_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mx_q    <= mx_d;
      pend_q  <= pend_d;
      col_q   <= col_d;
      elem_q  <= elem_d;
      grp_q   <= grp_d;
      drn_q   <= drn_d;
`ifdef CONV1_SEQ_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Strobes decode from registered state; halt is the only input allowed to gate them.
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.fea_req  = (state_q == S_FETCH) && !bus.halt;
  assign bus.elem_v   = (state_q == S_ISSUE) && !mx_q && !bus.halt;
  assign bus.mx_issue = (state_q == S_ISSUE) &&  mx_q && !bus.halt;
  assign bus.acc_clr  = (state_q == S_CLEAR) && !bus.halt;
  assign bus.done     = (state_q == S_DONE)  && !bus.halt;
  assign bus.col_sel  = col_q;
  assign bus.grp_cnt  = grp_q;
`ifdef CONV1_SEQ_STALL_CNT_EN
  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_conv1_dense_seq_ctrl.sv
// Scoreboard bench for conv1_dense_seq_ctrl: instance A (ACC_LEN=75) and B (ACC_LEN=30), NUM_GRP=2.
module tb_conv1_dense_seq_ctrl;
  localparam int NUM_GRP = 2;
  localparam int NUM_COL = 25;
  localparam int COL_W   = 5;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {EV_FETCH, EV_ELEM, EV_MX, EV_CLR, EV_DONE} ev_e;
  typedef struct packed {ev_e kind; logic [COL_W-1:0] col;} ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_d = 1'b0, cfg_d = 1'b0, halt_d = 1'b0, fea_v_d = 1'b0, sel_b = 1'b0;
  logic start_req = 1'b0, halt_req = 1'b0, rst_req = 1'b1;

  conv1_dense_seq_ctrl_if #(.COL_W(COL_W), .CNT_W(CNT_W)) if_a ();
  conv1_dense_seq_ctrl_if #(.COL_W(COL_W), .CNT_W(CNT_W)) if_b ();

  assign if_a.start     = start_d & ~sel_b;
  assign if_a.cfg_mx_en = cfg_d;
  assign if_a.halt      = halt_d & ~sel_b;
  assign if_a.fea_v     = fea_v_d & ~sel_b;
  assign if_b.start     = start_d & sel_b;
  assign if_b.cfg_mx_en = cfg_d;
  assign if_b.halt      = halt_d & sel_b;
  assign if_b.fea_v     = fea_v_d & sel_b;

  conv1_dense_seq_ctrl #(.ACC_LEN(75), .NUM_GRP(NUM_GRP)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  conv1_dense_seq_ctrl #(.ACC_LEN(30), .NUM_GRP(NUM_GRP)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  wire             m_fea_req = sel_b ? if_b.fea_req  : if_a.fea_req;
  wire             m_elem_v  = sel_b ? if_b.elem_v   : if_a.elem_v;
  wire             m_mx      = sel_b ? if_b.mx_issue : if_a.mx_issue;
  wire             m_clr     = sel_b ? if_b.acc_clr  : if_a.acc_clr;
  wire             m_busy    = sel_b ? if_b.busy     : if_a.busy;
  wire             m_done    = sel_b ? if_b.done     : if_a.done;
  wire [COL_W-1:0] m_col     = sel_b ? if_b.col_sel  : if_a.col_sel;
  wire [CNT_W-1:0] m_grp     = sel_b ? if_b.grp_cnt  : if_a.grp_cnt;

  always #5 clk = ~clk;

  int  n_checks = 0, n_fail = 0;
  ev_t sb_q[$];
  int  cyc = 0, last_issue = 0, exp_gap = 4, exp_grp = 0, done_cnt = 0;
  int  elem_seen = 0, mx_seen = 0, fea_seen = 0, fea_cd = 0;

  function automatic ev_t mk_ev(ev_e k, int c);
    ev_t e;
    e.kind = k;
    e.col  = COL_W'(c);
    return e;
  endfunction

  // One clock: drive inputs just after posedge, then sample and score at negedge.
  task automatic cycle();
    ev_t got, exp;
    bit  has;
    @(posedge clk);
    #1;
    rst       = rst_req;
    start_d   = start_req;
    start_req = 1'b0;
    halt_d    = halt_req;
    if (fea_cd == 1) begin
      fea_v_d = 1'b1;
      fea_cd  = 0;
    end else begin
      fea_v_d = 1'b0;
      if (fea_cd > 1) fea_cd--;
    end
    @(negedge clk);
    cyc++;
    if (!rst) begin
      has = 1'b1;
      got = mk_ev(EV_FETCH, int'(m_col));
      if (m_fea_req)     got.kind = EV_FETCH;
      else if (m_elem_v) got.kind = EV_ELEM;
      else if (m_mx)     got.kind = EV_MX;
      else if (m_clr)    got.kind = EV_CLR;
      else if (m_done)   got.kind = EV_DONE;
      else               has = 1'b0;
      if (has) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got %s col %0d, expected no event", got.kind.name(), got.col);
        end else begin
          exp = sb_q.pop_front();
          if (exp.kind !== got.kind || (got.kind == EV_ELEM && exp.col !== got.col)) begin
            n_fail++;
            $display("FAIL sb_event @%0d: got %s col %0d, expected %s col %0d",
                     cyc, got.kind.name(), got.col, exp.kind.name(), exp.col);
          end
        end
        case (got.kind)
          EV_FETCH: fea_seen++;
          EV_ELEM:  begin elem_seen++; last_issue = cyc; end
          EV_MX:    begin mx_seen++;   last_issue = cyc; end
          EV_CLR: begin
            n_checks++;
            if (cyc - last_issue !== exp_gap) begin
              n_fail++;
              $display("FAIL clr_gap: got %0d cycles, expected %0d", cyc - last_issue, exp_gap);
            end
            n_checks++;
            if (m_grp !== CNT_W'(exp_grp)) begin
              n_fail++;
              $display("FAIL grp_at_clr: got %0d, expected %0d", m_grp, exp_grp);
            end
            exp_grp++;
          end
          default: done_cnt++;
        endcase
      end
      if (m_fea_req) fea_cd = 2;
    end
  endtask

  task automatic do_reset();
    rst_req   = 1'b1;
    halt_req  = 1'b0;
    start_req = 1'b0;
    repeat (2) cycle();
    rst_req = 1'b0;
    cycle();
    sb_q.delete();
    fea_cd = 0; exp_grp = 0; done_cnt = 0; last_issue = 0;
    elem_seen = 0; mx_seen = 0; fea_seen = 0;
  endtask

  task automatic push_bypass(input int acc);
    int col = 0;
    bit need = 1'b1;
    for (int g = 0; g < NUM_GRP; g++) begin
      for (int e = 0; e < acc; e++) begin
        if (need) sb_q.push_back(mk_ev(EV_FETCH, 0));
        sb_q.push_back(mk_ev(EV_ELEM, col));
        col++;
        need = 1'b0;
        if (col == NUM_COL) begin col = 0; need = 1'b1; end
      end
      sb_q.push_back(mk_ev(EV_CLR, 0));
    end
    sb_q.push_back(mk_ev(EV_DONE, 0));
  endtask

  task automatic push_mx(input int acc);
    for (int g = 0; g < NUM_GRP; g++) begin
      for (int e = 0; e < acc; e++) begin
        sb_q.push_back(mk_ev(EV_FETCH, 0));
        sb_q.push_back(mk_ev(EV_MX, 0));
      end
      sb_q.push_back(mk_ev(EV_CLR, 0));
    end
    sb_q.push_back(mk_ev(EV_DONE, 0));
  endtask

  task automatic run_pass(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    cycle();
  endtask

  task automatic test_reset();
    sel_b = 1'b0; rst_req = 1'b1;
    cycle();
    n_checks++;
    if ({m_fea_req, m_elem_v, m_mx, m_clr, m_busy, m_done} !== 6'b0 || m_col !== '0 || m_grp !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: strobes %b col %0d grp %0d, expected all 0",
               {m_fea_req, m_elem_v, m_mx, m_clr, m_busy, m_done}, m_col, m_grp);
    end
    do_reset();
    cycle();
    n_checks++;
    if ({m_fea_req, m_elem_v, m_mx, m_clr, m_busy, m_done} !== 6'b0 || m_col !== '0 || m_grp !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: strobes %b col %0d grp %0d, expected all 0",
               {m_fea_req, m_elem_v, m_mx, m_clr, m_busy, m_done}, m_col, m_grp);
    end
  endtask

  task automatic test_bypass();
    bit to;
    sel_b = 1'b0; cfg_d = 1'b0;
    do_reset();
    exp_gap = 4;
    push_bypass(75);
    start_req = 1'b1;
    run_pass(3000, to);
    n_checks++; if (to !== 1'b0)       begin n_fail++; $display("FAIL byp_timeout: no done within budget"); end
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL byp_left: %0d events left, expected 0", sb_q.size()); end
    n_checks++; if (elem_seen !== 150) begin n_fail++; $display("FAIL byp_elems: got %0d, expected 150", elem_seen); end
    n_checks++; if (fea_seen !== 6)    begin n_fail++; $display("FAIL byp_fetches: got %0d, expected 6", fea_seen); end
    n_checks++; if (done_cnt !== 1)    begin n_fail++; $display("FAIL byp_done: got %0d pulses, expected 1", done_cnt); end
    n_checks++; if (m_grp !== CNT_W'(2) || m_busy !== 1'b0) begin
      n_fail++; $display("FAIL byp_end: grp %0d busy %b, expected grp 2 busy 0", m_grp, m_busy);
    end
  endtask

  task automatic test_mx();
    bit to;
    sel_b = 1'b0; cfg_d = 1'b1;
    do_reset();
    exp_gap = 10;
    push_mx(75);
    start_req = 1'b1;
    run_pass(5000, to);
    cfg_d = 1'b0;
    n_checks++; if (to !== 1'b0)       begin n_fail++; $display("FAIL mx_timeout: no done within budget"); end
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL mx_left: %0d events left, expected 0", sb_q.size()); end
    n_checks++; if (mx_seen !== 150 || elem_seen !== 0) begin
      n_fail++; $display("FAIL mx_counts: mx %0d elem %0d, expected 150 and 0", mx_seen, elem_seen);
    end
    n_checks++; if (m_grp !== CNT_W'(2) || done_cnt !== 1) begin
      n_fail++; $display("FAIL mx_end: grp %0d done %0d, expected 2 and 1", m_grp, done_cnt);
    end
  endtask

  task automatic test_halt_issue();
    bit to, found;
    sel_b = 1'b0; cfg_d = 1'b0;
    do_reset();
    exp_gap = 4;
    push_bypass(75);
    start_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      found = m_elem_v && m_col == COL_W'(9);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL halt_find: col 9 never issued, expected within 200 cycles"); end
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (m_elem_v !== 1'b0 || m_col !== COL_W'(10)) begin
        n_fail++; $display("FAIL halt_hold %0d: elem_v %b col %0d, expected 0 and 10", i, m_elem_v, m_col);
      end
    end
    halt_req = 1'b0;
    run_pass(3000, to);
    n_checks++; if (to !== 1'b0 || sb_q.size() !== 0) begin
      n_fail++; $display("FAIL halt_end: timeout %b left %0d, expected 0 and 0", to, sb_q.size());
    end
    n_checks++; if (elem_seen !== 150) begin n_fail++; $display("FAIL halt_elems: got %0d, expected 150", elem_seen); end
  endtask

  task automatic test_group_straddle();
    bit to;
    sel_b = 1'b1; cfg_d = 1'b0;
    do_reset();
    exp_gap = 4;
    push_bypass(30);
    start_req = 1'b1;
    run_pass(3000, to);
    n_checks++; if (to !== 1'b0 || sb_q.size() !== 0) begin
      n_fail++; $display("FAIL strad_end: timeout %b left %0d, expected 0 and 0", to, sb_q.size());
    end
    n_checks++; if (fea_seen !== 3 || elem_seen !== 60) begin
      n_fail++; $display("FAIL strad_counts: fetch %0d elem %0d, expected 3 and 60", fea_seen, elem_seen);
    end
    n_checks++; if (m_grp !== CNT_W'(2)) begin n_fail++; $display("FAIL strad_grp: got %0d, expected 2", m_grp); end
    sel_b = 1'b0;
  endtask

  task automatic test_halt_fea_restart();
    bit to, found;
    sel_b = 1'b0; cfg_d = 1'b0;
    do_reset();
    exp_gap = 4;
    push_bypass(75);
    start_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = m_fea_req;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL pend_find: no fea_req, expected within 20 cycles"); end
    halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (m_elem_v !== 1'b0 || m_busy !== 1'b1) begin
        n_fail++; $display("FAIL pend_halt %0d: elem_v %b busy %b, expected 0 and 1", i, m_elem_v, m_busy);
      end
    end
    halt_req = 1'b0;
    cycle();
    n_checks++; if (m_elem_v !== 1'b0) begin n_fail++; $display("FAIL pend_wait: elem_v %b, expected 0", m_elem_v); end
    cycle();
    n_checks++; if (m_elem_v !== 1'b1 || m_col !== '0) begin
      n_fail++; $display("FAIL pend_issue: elem_v %b col %0d, expected 1 and 0", m_elem_v, m_col);
    end
    repeat (20) cycle();
    start_req = 1'b1;
    cycle();
    cycle();
    n_checks++; if (m_grp !== CNT_W'(exp_grp) || m_busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_ign: grp %0d busy %b, expected %0d and 1", m_grp, m_busy, exp_grp);
    end
    run_pass(3000, to);
    n_checks++; if (to !== 1'b0 || sb_q.size() !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL pend_end: timeout %b left %0d done %0d, expected 0 0 1", to, sb_q.size(), done_cnt);
    end
    n_checks++; if (m_grp !== CNT_W'(2)) begin n_fail++; $display("FAIL pend_grp: got %0d, expected 2", m_grp); end
  endtask

  task automatic test_async_reset();
    bit found;
    sel_b = 1'b0; cfg_d = 1'b0;
    do_reset();
    exp_gap = 4;
    push_bypass(75);
    start_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      found = m_elem_v && m_col == COL_W'(12);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL arst_find: col 12 never issued, expected within 200 cycles"); end
    rst_req = 1'b1;
    cycle();
    n_checks++;
    if ({m_fea_req, m_elem_v, m_mx, m_clr, m_busy, m_done} !== 6'b0 || m_col !== '0 || m_grp !== '0) begin
      n_fail++;
      $display("FAIL arst_out: strobes %b col %0d grp %0d, expected all 0",
               {m_fea_req, m_elem_v, m_mx, m_clr, m_busy, m_done}, m_col, m_grp);
    end
    test_bypass();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_mx();
    test_halt_issue();
    test_group_straddle();
    test_halt_fea_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
